// File: rtl/sad_pkg.sv
// Shared definitions for the SAD engines and the hexagon search controller:
// state encoding, default widths and the accumulator width derivation.
package sad_pkg;

  localparam int PIX_W_DEF      = 8;
  localparam int BLK_PIXELS_DEF = 16;
  localparam int ID_W_DEF       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sad_state_e;

  // Accumulator width that holds BLK_PIXELS * (2^PIX_W - 1) without overflow.
  function automatic int sad_width(input int pix_w, input int blk_pixels);
    return pix_w + $clog2(blk_pixels);
  endfunction

endpackage

// File: rtl/abs_diff_8bit.sv
// Carry-select absolute difference |a - b| of two unsigned pixels.
// Both two's-complement differences are formed; the carry-out of a-b picks one.
module abs_diff_8bit #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] diff
);

  logic [PIX_W:0] a_minus_b_s;
  logic [PIX_W:0] b_minus_a_s;

  // Carry-out of a + ~b + 1 is set exactly when a >= b.
  always_comb begin
    a_minus_b_s = {1'b0, a} + {1'b0, ~b} + {{PIX_W{1'b0}}, 1'b1};
    b_minus_a_s = {1'b0, b} + {1'b0, ~a} + {{PIX_W{1'b0}}, 1'b1};
    if (a_minus_b_s[PIX_W]) begin
      diff = a_minus_b_s[PIX_W-1:0];
    end else begin
      diff = b_minus_a_s[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/sad_block_accum.sv
// Streaming SAD accumulator for one block plus best-candidate tracking
// across the search points of a hexagon step.
module sad_block_accum
  import sad_pkg::*;
#(
  parameter  int PIX_W      = PIX_W_DEF,
  parameter  int BLK_PIXELS = BLK_PIXELS_DEF,
  parameter  int ID_W       = ID_W_DEF,
  localparam int SAD_W      = sad_width(PIX_W, BLK_PIXELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ID_W-1:0]  cand_id,
  input  logic             clear_best,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  output logic             sad_valid,
  input  logic             sad_ready,
  output logic [SAD_W-1:0] sad_out,
  output logic [ID_W-1:0]  sad_id,
  output logic [SAD_W-1:0] best_sad,
  output logic [ID_W-1:0]  best_id,
  output logic             busy
);

  localparam int CNT_W = $clog2(BLK_PIXELS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLK_PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sad_state_e       state_r;
  sad_state_e       state_s;
  logic [CNT_W-1:0] take_cnt_r;
  logic [CNT_W-1:0] absorb_cnt_r;
  logic [PIX_W-1:0] diff_s;
  logic [PIX_W-1:0] diff_r;
  logic             diff_vld_r;
  logic [SAD_W-1:0] acc_r;
  logic [ID_W-1:0]  id_r;
  logic [SAD_W-1:0] sad_out_r;
  logic [ID_W-1:0]  sad_id_r;
  logic [SAD_W-1:0] best_sad_r;
  logic [ID_W-1:0]  best_id_r;
  logic             take_s;
  logic             sad_hs_s;
  logic             begin_s;
  logic             finish_s;

  abs_diff_8bit #(.PIX_W(PIX_W)) u_abs_diff (
    .a    (cur_pix),
    .b    (ref_pix),
    .diff (diff_s)
  );

  assign in_ready  = (state_r == ACCUM);
  assign sad_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign sad_out   = sad_out_r;
  assign sad_id    = sad_id_r;
  assign best_sad  = best_sad_r;
  assign best_id   = best_id_r;

  assign take_s   = in_valid && (state_r == ACCUM);
  assign sad_hs_s = sad_ready && (state_r == DONE);
  assign begin_s  = start && (state_r == IDLE);
  assign finish_s = (state_r == DRAIN) && (absorb_cnt_r == CNT_FULL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = ACCUM;
        else       state_s = IDLE;
      end
      ACCUM: begin
        if (take_s && (take_cnt_r == CNT_LAST)) state_s = DRAIN;
        else                                    state_s = ACCUM;
      end
      DRAIN: begin
        if (absorb_cnt_r == CNT_FULL) state_s = DONE;
        else                          state_s = DRAIN;
      end
      DONE: begin
        if (sad_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Two-stage datapath: registered |cur-ref|, then accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_cnt_r   <= {CNT_W{1'b0}};
      absorb_cnt_r <= {CNT_W{1'b0}};
      diff_r       <= {PIX_W{1'b0}};
      diff_vld_r   <= 1'b0;
      acc_r        <= {SAD_W{1'b0}};
      id_r         <= {ID_W{1'b0}};
    end else if (begin_s) begin
      take_cnt_r   <= {CNT_W{1'b0}};
      absorb_cnt_r <= {CNT_W{1'b0}};
      diff_vld_r   <= 1'b0;
      acc_r        <= {SAD_W{1'b0}};
      id_r         <= cand_id;
    end else begin
      diff_vld_r <= take_s;
      if (take_s) begin
        diff_r     <= diff_s;
        take_cnt_r <= take_cnt_r + CNT_ONE;
      end else begin
        diff_r     <= diff_r;
        take_cnt_r <= take_cnt_r;
      end
      if (diff_vld_r) begin
        acc_r        <= acc_r + {{(SAD_W-PIX_W){1'b0}}, diff_r};
        absorb_cnt_r <= absorb_cnt_r + CNT_ONE;
      end else begin
        acc_r        <= acc_r;
        absorb_cnt_r <= absorb_cnt_r;
      end
    end
  end

  // Result register: captured on entry to DONE, held through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_out_r <= {SAD_W{1'b0}};
      sad_id_r  <= {ID_W{1'b0}};
    end else if (finish_s) begin
      sad_out_r <= acc_r;
      sad_id_r  <= id_r;
    end else begin
      sad_out_r <= sad_out_r;
      sad_id_r  <= sad_id_r;
    end
  end

  // Best tracker: strict less-than keeps the earlier ID on ties; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad_r <= {SAD_W{1'b1}};
      best_id_r  <= {ID_W{1'b0}};
    end else if (clear_best) begin
      best_sad_r <= {SAD_W{1'b1}};
      best_id_r  <= {ID_W{1'b0}};
    end else if (sad_hs_s && (sad_out_r < best_sad_r)) begin
      best_sad_r <= sad_out_r;
      best_id_r  <= sad_id_r;
    end else begin
      best_sad_r <= best_sad_r;
      best_id_r  <= best_id_r;
    end
  end

endmodule
